rom_streamer: RTL and testbench

ROM_STREAMER -- requirements
Module: rom_streamer

---
 rtl/rom_streamer_pkg.sv | 14 +
 rtl/rom_streamer_if.sv | 28 ++
 rtl/stream_fifo2.sv | 41 ++++
 rtl/rom_streamer.sv | 105 ++++++++++
 tb/tb_rom_streamer.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/rom_streamer_pkg.sv
// rom_streamer shared types and defaults.
// Burst FSM states and default ROM geometry.
package rom_streamer_pkg;

  localparam int ADDR_W_DEF = 12;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_e;

endpackage

// File: rtl/rom_streamer_if.sv
// Valid/ready word stream leaving the ROM streamer.
// master drives valid/data/last; slave drives ready.
interface rom_streamer_if
  import rom_streamer_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_W_DEF
) ();

  logic                  valid;
  logic                  ready;
  logic [DATA_WIDTH-1:0] data;
  logic                  last;

  modport master (
    output valid,
    output data,
    output last,
    input  ready
  );

  modport slave (
    input  valid,
    input  data,
    input  last,
    output ready
  );

endinterface

// File: rtl/stream_fifo2.sv
// Two-entry FIFO; push and pop may coincide at any occupancy.
// Caller guarantees no push when full unless also popping.
module stream_fifo2 #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic [1:0]   count
);

  logic [W-1:0] mem [2];
  logic         wp;
  logic         rp;

  assign dout = mem[rp];

  always_ff @(posedge clk) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wp     <= 1'b0;
      rp     <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wp] <= din;
        wp      <= ~wp;
      end
      if (pop) begin
        rp <= ~rp;
      end
      count <= count + {1'b0, push}
                     - {1'b0, pop};
    end
  end

endmodule

// File: rtl/rom_streamer.sv
// Streams a burst of consecutive ROM words onto a
// valid/ready interface with credit-limited reads.
module rom_streamer
  import rom_streamer_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_W_DEF,
  parameter int DATA_WIDTH = DATA_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   length,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_data,
  rom_streamer_if.master        m
);

  localparam logic [ADDR_WIDTH:0] ONE = 1;

  state_e                state;
  logic [ADDR_WIDTH:0]   rem;
  logic                  rd_v;
  logic                  rd_last;
  logic [DATA_WIDTH:0]   head;
  logic [1:0]            occ;
  logic [2:0]            credit;
  logic                  pop;
  logic                  issue;

  assign m.valid = (occ != 2'd0);
  assign m.data  = head[DATA_WIDTH-1:0];
  assign m.last  = head[DATA_WIDTH];
  assign pop     = m.valid & m.ready;

  // Slots still committed after this cycle's pop
  assign credit = {1'b0, occ}
                + {2'b0, rd_v}
                - {2'b0, pop};
  assign issue  = (state == RUN)
                && (credit < 3'd2);

  stream_fifo2 #(
    .W(DATA_WIDTH + 1)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rd_v),
    .din   ({rd_last, rom_data}),
    .pop   (pop),
    .dout  (head),
    .count (occ)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      rom_addr <= '0;
      rem      <= '0;
      rd_v     <= 1'b0;
      rd_last  <= 1'b0;
    end else begin
      done    <= 1'b0;
      rd_v    <= issue;
      rd_last <= issue && (rem == ONE);
      unique case (state)
        IDLE: begin
          if (start) begin
            if (length == '0) begin
              done <= 1'b1;
            end else begin
              state    <= RUN;
              busy     <= 1'b1;
              rom_addr <= base_addr;
              rem      <= length;
            end
          end
        end
        RUN: begin
          if (issue) begin
            rom_addr <= rom_addr
                      + ADDR_WIDTH'(1);
            rem      <= rem - ONE;
            if (rem == ONE) begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (pop && m.last) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rom_streamer.sv
// Bench for rom_streamer: vector table, hand sequences
// and random bursts checked against a queue model.
module tb_rom_streamer;

  logic        clk;
  logic        rst;
  logic        start;
  logic [11:0] base_addr;
  logic [12:0] length;
  logic        busy;
  logic        done;
  logic [11:0] rom_addr;
  logic [7:0]  rom_data;

  int total;
  int passed;

  logic [8:0] exp_q[$];

  rom_streamer_if #(.DATA_WIDTH(8)) m ();

  rom_streamer #(
    .ADDR_WIDTH(12),
    .DATA_WIDTH(8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .length    (length),
    .busy      (busy),
    .done      (done),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .m         (m)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] rom_fn(
    input logic [11:0] a
  );
    int v;
    v = int'(a) * 37 + int'(a >> 5);
    return v[7:0];
  endfunction

  // Synchronous ROM: data valid one cycle after address
  always @(posedge clk) rom_data <= rom_fn(rom_addr);

  task automatic chk(
    input string  nm,
    input longint got,
    input longint exp
  );
    total++;
    if (got == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d",
                  nm, got, exp);
  endtask

  typedef struct {
    logic [11:0] base;
    logic [12:0] len;
    int          mode;
    int          restart;
    int          exp_done;
  } vec_t;

  task automatic run_burst(
    input logic [11:0] b,
    input logic [12:0] l,
    input int          mode,
    input int          restart,
    input int          exp_done
  );
    int n, done_n, first_v, words, bubbles;
    bit stall, busy_seen;
    logic [8:0]  held, e;
    logic [11:0] a;
    for (int k = 0; k < int'(l); k++) begin
      a = b + 12'(k);
      exp_q.push_back({k == int'(l) - 1, rom_fn(a)});
    end
    @(negedge clk);
    start = 1'b1; base_addr = b; length = l;
    @(negedge clk);
    start = 1'b0; base_addr = '0; length = '0;
    n = 0; done_n = -1; first_v = -1;
    words = 0; bubbles = 0;
    stall = 1'b0; busy_seen = 1'b0;
    held = '0;
    while (done_n < 0 && n < 300 + 4 * int'(l)) begin
      case (mode)
        0:       m.ready = 1'b1;
        1:       m.ready = (n % 2 == 0);
        default: m.ready = ($urandom_range(0, 3) != 0);
      endcase
      if (n == restart) begin
        start = 1'b1; base_addr = 12'd100;
        length = 13'd7;
      end else begin
        start = 1'b0;
      end
      busy_seen |= busy;
      if (stall) begin
        chk("hold_data", {m.last, m.data}, held);
        chk("hold_valid", m.valid, 1);
      end
      stall = 1'b0;
      if (m.valid) begin
        if (first_v < 0) first_v = n;
        if (m.ready) begin
          words++;
          if (exp_q.size() == 0) begin
            chk("extra_word", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk("word", {m.last, m.data}, e);
          end
        end else begin
          stall = 1'b1;
          held  = {m.last, m.data};
        end
      end else if (first_v >= 0 && words < int'(l)) begin
        bubbles++;
      end
      if (done) begin
        done_n = n;
        chk("busy_at_done", busy, 0);
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    m.ready = 1'b1;
    chk("done_seen", done_n >= 0, 1);
    if (exp_done >= 0) chk("done_cycle", done_n, exp_done);
    chk("word_count", words, l);
    chk("queue_empty", exp_q.size(), 0);
    if (l == 0) begin
      chk("busy_len0", busy_seen, 0);
      chk("valid_len0", first_v, -1);
    end else begin
      chk("first_valid", first_v, 2);
    end
    if (mode == 0) chk("bubbles", bubbles, 0);
    chk("done_pulse", done, 0);
    chk("idle_valid", m.valid, 0);
    exp_q.delete();
  endtask

  initial begin
    vec_t        tbl[6];
    int          words, n, r;
    bit          any_done, any_valid;
    logic [11:0] a;
    logic [12:0] l;
    total = 0; passed = 0;
    tbl[0] = '{12'd10,   13'd4, 0, -1,  6};
    tbl[1] = '{12'd4094, 13'd4, 0, -1,  6};
    tbl[2] = '{12'd7,    13'd5, 1, -1, -1};
    tbl[3] = '{12'd33,   13'd0, 0, -1,  0};
    tbl[4] = '{12'd20,   13'd8, 0,  3, 10};
    tbl[5] = '{12'd4095, 13'd1, 0, -1,  3};

    rst = 1'b1; start = 1'b0;
    base_addr = '0; length = '0; m.ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_valid", m.valid, 0);
    chk("rst_last", m.last, 0);
    chk("rst_data", m.data, 0);
    chk("rst_addr", rom_addr, 0);
    rst = 1'b0;

    for (int i = 0; i < 6; i++)
      run_burst(tbl[i].base, tbl[i].len, tbl[i].mode,
                tbl[i].restart, tbl[i].exp_done);

    // Abort an 8-word burst after two words
    @(negedge clk);
    start = 1'b1; base_addr = 12'd200;
    length = 13'd8; m.ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    words = 0; n = 0;
    while (words < 2 && n < 50) begin
      if (m.valid && m.ready) begin
        a = 12'd200 + 12'(words);
        chk("pre_rst_word", m.data, rom_fn(a));
        words++;
      end
      if (words < 2) begin
        @(negedge clk);
        n++;
      end
    end
    chk("pre_rst_words", words, 2);
    rst = 1'b1; start = 1'b1;
    base_addr = 12'd5; length = 13'd3;
    @(negedge clk);
    start = 1'b0; base_addr = '0; length = '0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_valid", m.valid, 0);
    chk("abort_last", m.last, 0);
    chk("abort_data", m.data, 0);
    chk("abort_addr", rom_addr, 0);
    rst = 1'b0;
    any_done = 1'b0; any_valid = 1'b0;
    repeat (10) begin
      @(negedge clk);
      any_done  |= done;
      any_valid |= m.valid;
      any_valid |= busy;
    end
    chk("abort_no_done", any_done, 0);
    chk("abort_quiet", any_valid, 0);
    run_burst(12'd0, 13'd1, 0, -1, 3);

    for (int i = 0; i < 25; i++) begin
      r = $urandom_range(0, 9);
      if (r == 0) l = 13'd0;
      else if (r == 1) l = 13'($urandom_range(1, 40));
      else l = 13'($urandom_range(1, 6));
      if (r == 2) a = 12'(4090 + $urandom_range(0, 5));
      else a = 12'($urandom_range(0, 4095));
      run_burst(a, l, 2, -1, -1);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
